// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha1_pkg
// Brief    : SHA-1 state types, IV/K constants and round helper functions
// Revision : 1.0
// ============================================================================
package sha1_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_words_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    localparam sha1_words_t SHA1_IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                       32'h10325476, 32'hc3d2e1f0};

    localparam logic [31:0] SHA1_K0 = 32'h5a827999;
    localparam logic [31:0] SHA1_K1 = 32'h6ed9eba1;
    localparam logic [31:0] SHA1_K2 = 32'h8f1bbcdc;
    localparam logic [31:0] SHA1_K3 = 32'hca62c1d6;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20)      return SHA1_K0;
        else if (t < 7'd40) return SHA1_K1;
        else if (t < 7'd60) return SHA1_K2;
        else                return SHA1_K3;
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    // Rounds per clock must tile the 80 rounds exactly and stay within the W lookahead.
    function automatic bit rpc_legal(input int rpc);
        return (rpc >= 1) && (rpc <= 20) && ((80 % rpc) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_round.sv
`default_nettype none
// ============================================================================
// Module   : sha1_round
// Brief    : one combinational SHA-1 round step (a..e, W[t], t -> next a..e)
// Revision : 1.0
// ============================================================================
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_words_t st_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  t_i,
    output sha1_words_t st_o
);

    logic [31:0] temp;

    always_comb begin
        temp   = rotl(st_i.a, 5) + sha1_f(t_i, st_i.b, st_i.c, st_i.d) + st_i.e
               + sha1_k(t_i) + w_i;
        st_o.a = temp;
        st_o.b = st_i.a;
        st_o.c = rotl(st_i.b, 30);
        st_o.d = st_i.c;
        st_o.e = st_i.d;
    end

endmodule
`default_nettype wire

// File: rtl/sha1_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : sha1_stream_core
// Brief    : multi-block SHA-1 engine, RPC rounds/clock, chained across blocks
// Revision : 1.0
// ============================================================================
module sha1_stream_core
    import sha1_pkg::*;
#(
    parameter int RPC   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_first,
    input  logic             blk_last,
    input  logic             abort,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [159:0]     dig_data,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam logic [6:0] T_STEP = 7'(RPC);
    localparam logic [6:0] T_LAST = 7'(80 - RPC);

    if (!rpc_legal(RPC)) begin : g_rpc_check
        $error("sha1_stream_core: RPC must divide 80 and lie in 1..20");
    end

    state_t           state_q, state_d;
    logic [6:0]       t_q, t_d;
    logic [31:0]      w_q [16];
    logic [31:0]      w_d [16];
    sha1_words_t      abcde_q, abcde_d;
    sha1_words_t      h_q, h_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic             fin_q, fin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [159:0]     dig_q, dig_d;
    logic             dig_valid_q, dig_valid_d;
    logic             blk_ready_q, blk_ready_d;
    logic             busy_q, busy_d;

    // Message schedule extended by RPC words so every round of this cycle has its W.
    logic [31:0] w_ext [16+RPC];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = w_q[i];
        end
        for (int j = 0; j < RPC; j++) begin
            w_ext[16+j] = rotl(w_ext[13+j] ^ w_ext[8+j] ^ w_ext[2+j] ^ w_ext[j], 1);
        end
    end

    sha1_words_t round_out;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        sha1_words_t st_in;
        sha1_words_t st_out;
        if (j == 0) begin : g_head
            assign st_in = abcde_q;
        end else begin : g_link
            assign st_in = g_round[j-1].st_out;
        end
        sha1_round u_round (
            .st_i (st_in),
            .w_i  (w_ext[j]),
            .t_i  (t_q + 7'(j)),
            .st_o (st_out)
        );
    end

    assign round_out = g_round[RPC-1].st_out;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        w_d         = w_q;
        abcde_d     = abcde_q;
        h_d         = h_q;
        last_d      = last_q;
        first_d     = first_q;
        fin_d       = fin_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        dig_valid_d = dig_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    h_d     = blk_first ? SHA1_IV : h_q;
                    abcde_d = blk_first ? SHA1_IV : h_q;
                    last_d  = blk_last;
                    first_d = blk_first;
                    fin_d   = 1'b0;
                    t_d     = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                abcde_d = round_out;
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = w_ext[i + RPC];
                end
                t_d = t_q + T_STEP;
                if (t_q == T_LAST) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // A last block spends a second UPDATE cycle registering the digest.
                if (!fin_q) begin
                    h_d.a = h_q.a + abcde_q.a;
                    h_d.b = h_q.b + abcde_q.b;
                    h_d.c = h_q.c + abcde_q.c;
                    h_d.d = h_q.d + abcde_q.d;
                    h_d.e = h_q.e + abcde_q.e;
                    cnt_d = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
                    if (last_q) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dig_d       = h_q;
                    dig_valid_d = 1'b1;
                    fin_d       = 1'b0;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dig_ready) begin
                    dig_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks any handshake evaluated above.
        if (abort) begin
            state_d     = ST_IDLE;
            dig_valid_d = 1'b0;
            cnt_d       = '0;
            h_d         = SHA1_IV;
            fin_d       = 1'b0;
        end

        blk_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            abcde_q     <= SHA1_IV;
            h_q         <= SHA1_IV;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            fin_q       <= 1'b0;
            cnt_q       <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            w_q         <= w_d;
            abcde_q     <= abcde_d;
            h_q         <= h_d;
            last_q      <= last_d;
            first_q     <= first_d;
            fin_q       <= fin_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
            blk_ready_q <= blk_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign dig_valid = dig_valid_q;
    assign dig_data  = dig_q;
    assign busy      = busy_q;
    assign blk_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sha1_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_stream_core
// Brief    : directed SHA-1 vectors on RPC=1/5/4 cores plus hold/abort/reset cases
// Revision : 1.0
// ============================================================================
module tb_sha1_stream_core;

    localparam logic [511:0] B_ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] B_TWO0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO1 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [511:0] B_EMP  = {32'h80000000, {15{32'h0}}};
    localparam logic [159:0] D_ABC  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] D_TWO  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    localparam logic [159:0] D_EMP  = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;

    typedef struct {
        int           dut;
        logic [511:0] b0;
        logic [511:0] b1;
        int           nblk;
        logic [159:0] dig;
        int           lat;
        int           cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bv  [3];
    logic         br  [3];
    logic [511:0] bd  [3];
    logic         bf  [3];
    logic         bl  [3];
    logic         ab  [3];
    logic         dv  [3];
    logic         dr  [3];
    logic [159:0] dd  [3];
    logic         bsy [3];
    logic [7:0]   bc  [3];

    int n_checks = 0;
    int n_errs   = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    sha1_stream_core #(.RPC(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .blk_valid(bv[0]), .blk_ready(br[0]), .blk_data(bd[0]),
        .blk_first(bf[0]), .blk_last(bl[0]), .abort(ab[0]), .dig_valid(dv[0]),
        .dig_ready(dr[0]), .dig_data(dd[0]), .busy(bsy[0]), .blk_cnt(bc[0]));

    sha1_stream_core #(.RPC(5), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .blk_valid(bv[1]), .blk_ready(br[1]), .blk_data(bd[1]),
        .blk_first(bf[1]), .blk_last(bl[1]), .abort(ab[1]), .dig_valid(dv[1]),
        .dig_ready(dr[1]), .dig_data(dd[1]), .busy(bsy[1]), .blk_cnt(bc[1]));

    sha1_stream_core #(.RPC(4), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .blk_valid(bv[2]), .blk_ready(br[2]), .blk_data(bd[2]),
        .blk_first(bf[2]), .blk_last(bl[2]), .abort(ab[2]), .dig_valid(dv[2]),
        .dig_ready(dr[2]), .dig_data(dd[2]), .busy(bsy[2]), .blk_cnt(bc[2]));

    task automatic chk(input string name, input int d, input logic [159:0] act,
                       input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s (dut%0d): got %h expected %h", name, d, act, exp);
        end
    endtask

    // Offers a block from a negedge until accepted; waited counts edges up to the accepting one.
    task automatic send_block(input int d, input logic [511:0] data, input logic first,
                              input logic last, output int waited, output logic saw_dig,
                              output logic acc);
        waited  = 0;
        saw_dig = 1'b0;
        acc     = 1'b0;
        bd[d] = data;
        bf[d] = first;
        bl[d] = last;
        bv[d] = 1'b1;
        while (!acc && waited < 400) begin
            acc = br[d];
            if (dv[d]) saw_dig = 1'b1;
            @(posedge clk);
            waited++;
            @(negedge clk);
        end
        bv[d] = 1'b0;
        bf[d] = 1'b0;
        bl[d] = 1'b0;
    endtask

    task automatic wait_digest(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dv[d] && lat < 400);
    endtask

    task automatic consume(input int d);
        dr[d] = 1'b1;
        @(posedge clk);
        #1;
        chk("dig_valid_clear", d, dv[d], 0);
        chk("ready_after_take", d, br[d], 1);
        @(negedge clk);
        dr[d] = 1'b0;
    endtask

    task automatic check_digest(input int d, input logic [159:0] dig, input int lat_exp,
                                input int lat, input int cnt);
        chk("latency", d, lat, lat_exp);
        chk("digest", d, dd[d], dig);
        chk("blk_cnt", d, bc[d], cnt);
        chk("out_blk_ready", d, br[d], 0);
        chk("out_busy", d, bsy[d], 1);
    endtask

    task automatic run_msg(input vec_t v);
        int   d;
        int   waited;
        int   lat;
        logic saw;
        logic acc;
        d = v.dut;
        if (v.nblk == 2) begin
            send_block(d, v.b0, 1'b1, 1'b0, waited, saw, acc);
            chk("accept_first", d, acc, 1);
            send_block(d, v.b1, 1'b0, 1'b1, waited, saw, acc);
            chk("block_spacing", d, waited, v.lat);
            chk("no_mid_digest", d, saw, 0);
        end else begin
            send_block(d, v.b0, 1'b1, 1'b1, waited, saw, acc);
            chk("accept", d, acc, 1);
        end
        wait_digest(d, lat);
        check_digest(d, v.dig, v.lat, lat, v.cnt);
        consume(d);
        chk("digest_retained", d, dd[d], v.dig);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   waited;
        int   lat;
        logic saw;
        logic acc;
        logic bad;

        vecs[0] = '{0, B_ABC,  '0,     1, D_ABC, 82, 1};
        vecs[1] = '{0, B_TWO0, B_TWO1, 2, D_TWO, 82, 2};
        vecs[2] = '{0, B_EMP,  '0,     1, D_EMP, 82, 1};
        vecs[3] = '{1, B_ABC,  '0,     1, D_ABC, 18, 1};
        vecs[4] = '{1, B_TWO0, B_TWO1, 2, D_TWO, 18, 2};
        vecs[5] = '{2, B_ABC,  '0,     1, D_ABC, 22, 1};
        vecs[6] = '{2, B_TWO0, B_TWO1, 2, D_TWO, 22, 2};

        for (int i = 0; i < 3; i++) begin
            bv[i] = 1'b0; bd[i] = '0; bf[i] = 1'b0; bl[i] = 1'b0; ab[i] = 1'b0; dr[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_blk_ready", i, br[i], 1);
            chk("rst_dig_valid", i, dv[i], 0);
            chk("rst_dig_data", i, dd[i], 0);
            chk("rst_busy", i, bsy[i], 0);
            chk("rst_blk_cnt", i, bc[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_msg(vecs[k]);
        end

        // Digest held while the consumer stalls; a block offered meanwhile must wait.
        send_block(0, B_ABC, 1'b1, 1'b1, waited, saw, acc);
        wait_digest(0, lat);
        chk("hold_latency", 0, lat, 82);
        bd[0] = B_EMP; bf[0] = 1'b1; bl[0] = 1'b1; bv[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_dig_valid", 0, dv[0], 1);
            chk("hold_dig_data", 0, dd[0], D_ABC);
            chk("hold_blk_ready", 0, br[0], 0);
        end
        dr[0] = 1'b1;
        send_block(0, B_EMP, 1'b1, 1'b1, waited, saw, acc);
        dr[0] = 1'b0;
        chk("accept_after_take", 0, waited, 2);
        wait_digest(0, lat);
        check_digest(0, D_EMP, 82, lat, 1);
        consume(0);

        // Abort around round 40, then abort racing a block offer.
        send_block(0, B_ABC, 1'b1, 1'b1, waited, saw, acc);
        repeat (40) @(negedge clk);
        ab[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 0, bsy[0], 0);
        chk("abort_blk_ready", 0, br[0], 1);
        chk("abort_blk_cnt", 0, bc[0], 0);
        chk("abort_dig_valid", 0, dv[0], 0);
        @(negedge clk);
        bd[0] = B_ABC; bf[0] = 1'b1; bl[0] = 1'b1; bv[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_blocks_accept", 0, bsy[0], 0);
        @(negedge clk);
        ab[0] = 1'b0; bv[0] = 1'b0; bf[0] = 1'b0; bl[0] = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dv[0] || bsy[0]) bad = 1'b1;
        end
        chk("abort_no_spurious", 0, bad, 0);
        // No blk_first: chaining must have been restored to the IV by the abort.
        send_block(0, B_ABC, 1'b0, 1'b1, waited, saw, acc);
        wait_digest(0, lat);
        check_digest(0, D_ABC, 82, lat, 1);
        consume(0);

        // Asynchronous reset in the middle of ROUND.
        send_block(0, B_ABC, 1'b1, 1'b1, waited, saw, acc);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_blk_ready", 0, br[0], 1);
        chk("arst_dig_valid", 0, dv[0], 0);
        chk("arst_dig_data", 0, dd[0], 0);
        chk("arst_busy", 0, bsy[0], 0);
        chk("arst_blk_cnt", 0, bc[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(0, B_EMP, 1'b0, 1'b1, waited, saw, acc);
        wait_digest(0, lat);
        check_digest(0, D_EMP, 82, lat, 1);
        consume(0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
